// File: rtl/nios_adc_led_ctrl.sv
// Avalon-MM LED/GPIO output controller: DATA register with atomic set/clear/toggle
// ports and a per-bit blink engine driven by a prescaled tick.
module nios_adc_led_ctrl #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned PRESCALE     = 50000,
  parameter logic [31:0] RESET_DATA   = 32'h0,
  parameter logic [15:0] RESET_PERIOD = 16'd250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned     PreW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax    = PreW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ResetData = RESET_DATA[WIDTH-1:0];

  typedef enum logic [2:0] {
    AddrData   = 3'd0,
    AddrBlink  = 3'd1,
    AddrPeriod = 3'd2,
    AddrRsvd   = 3'd3,
    AddrSet    = 3'd4,
    AddrClear  = 3'd5,
    AddrToggle = 3'd6,
    AddrStatus = 3'd7
  } addr_e;

  addr_e            addr;
  logic             wr;
  logic             period_wr;
  logic             tick;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [15:0]      period_q, period_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [15:0]      half_q, half_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] out_q, out_d;

  assign addr      = addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign period_wr = wr && (addr == AddrPeriod);
  assign wd        = writedata[WIDTH-1:0];
  assign tick      = (pre_q == PreMax);
  // Upper write-data bits are architecturally ignored when WIDTH < 32.
  assign unused_wd = ^writedata;

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr) begin
      case (addr)
        AddrData:   data_d   = wd;
        AddrBlink:  blink_d  = wd;
        AddrPeriod: period_d = writedata[15:0];
        AddrSet:    data_d   = data_q | wd;
        AddrClear:  data_d   = data_q & ~wd;
        AddrToggle: data_d   = data_q ^ wd;
        default:    ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and wins over any coincident tick.
  always_comb begin
    pre_d   = tick ? '0 : pre_q + PreW'(1);
    half_d  = half_q;
    phase_d = phase_q;
    if (period_wr) begin
      pre_d   = '0;
      half_d  = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      half_d  = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (half_q == period_q - 16'd1) begin
        half_d  = '0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 16'd1;
      end
    end
  end

  assign out_d = data_q & (~blink_q | {WIDTH{phase_q}});

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= ResetData;
      blink_q  <= '0;
      period_q <= RESET_PERIOD;
      pre_q    <= '0;
      half_q   <= '0;
      phase_q  <= 1'b1;
      out_q    <= '0;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      pre_q    <= pre_d;
      half_q   <= half_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (addr)
      AddrData:   readdata[WIDTH-1:0] = data_q;
      AddrBlink:  readdata[WIDTH-1:0] = blink_q;
      AddrPeriod: readdata[15:0]      = period_q;
      AddrStatus: readdata[0]         = phase_q;
      default:    ;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: doc/nios_adc_led_ctrl.md
# nios_adc_led_ctrl

Parametrised Avalon-MM LED/GPIO output controller for the Nios ADC system. It succeeds the fixed 10-bit LED PIO with three additions:
- configurable output width;
- atomic set/clear/toggle write ports;
- a per-bit hardware blink engine, so firmware no longer bit-bangs indicator LEDs.

It sits on the Nios data master as a zero-wait-state slave and drives board LEDs directly.

## Interface
- WIDTH, 10: number of output bits, 1..32.
- PRESCALE, 50000: clk cycles per blink tick, ≥1. At 50 MHz this gives a 1 ms tick.
- RESET_DATA, 0: DATA register value after reset.
- RESET_PERIOD, 250: PERIOD register value after reset, 16 bits.

Ports (clock and reset first):
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, read latency 0.
- out_port  out  WIDTH  registered LED drive.

One clock; reset is synchronous and active-high.

## Operation
Register map (word addresses). Bits above WIDTH, or above 16 for PERIOD, are ignored on write and read as 0.
- 0 DATA, RW: LED pattern.
- 1 BLINK_EN, RW: per-bit blink enable.
- 2 PERIOD, RW, 16 bits: blink half-period in ticks.
- 3: reserved; reads 0, writes ignored.
- 4 SET, WO: DATA |= wd.
- 5 CLEAR, WO: DATA &= ~wd.
- 6 TOGGLE, WO: DATA ^= wd.
- 7 STATUS, RO: bit0 = phase; bits 31:1 = 0.

Reads:
- A read of any WO address returns 0.
- A write occurs when chipselect=1 and write_n=0.
- Only one register is updated per cycle, so set/clear/toggle can never conflict.

Blink engine:
- pre_cnt counts 0..PRESCALE-1. tick=1 in the cycle pre_cnt = PRESCALE-1, then pre_cnt wraps to 0.
- On each tick, half_cnt increments.
- When half_cnt = PERIOD-1 and tick=1, half_cnt→0 and phase inverts.
- PERIOD=0: phase is forced to 1 and half_cnt is held at 0, so blinking bits appear steadily on.
- A write to PERIOD clears pre_cnt and half_cnt and sets phase=1 in that same cycle. This write takes priority over a coincident tick or wrap.
- Writes to DATA or BLINK_EN do not disturb the counters.

Output:
- Each clk: out_port ← DATA & (~BLINK_EN | {WIDTH{phase}}).
- An off bit (DATA=0) never lights, whether or not it blinks.

## Timing
Reset (reset=1 at a clk edge):
- DATA=RESET_DATA, BLINK_EN=0, PERIOD=RESET_PERIOD.
- pre_cnt=0, half_cnt=0, phase=1.
- out_port=0 at the reset edge, then RESET_DATA from the first edge after reset deasserts.
- Reset asserted mid-blink takes effect at that edge and overrides any coincident write.

Write latency:
- A register updates at the clk edge where the write is sampled (edge N).
- out_port reflects the update at edge N+1.

Read latency:
- readdata is valid in the same cycle as address/chipselect.
- No waitrequest.

Blink period:
- phase toggles every PRESCALE×PERIOD cycles.
- After a PERIOD write at edge N, the first toggle is at edge N+PRESCALE×PERIOD.
- out_port follows one edge later.

Counters:
- pre_cnt is ⌈log2 PRESCALE⌉ bits; PRESCALE=1 gives tick every cycle.
- half_cnt is 16 bits and wraps only via the PERIOD-1 compare.

## Test plan
Benches use WIDTH=10, PRESCALE=4, RESET_DATA=0x005, RESET_PERIOD=3.
- Reset/readback:
  - Hold reset 2 cycles → out_port=0x005 one edge after release.
  - Reads return 0x005, 0, 3, 0, 0, 0, 0, 1 at addresses 0..7.
  - Write 0xFFFFFFFF to DATA → reads 0x3FF.
- Atomic ops:
  - DATA=0x0F0.
  - SET 0x003 → 0x0F3.
  - CLEAR 0x030 → 0x0C3.
  - TOGGLE 0x101 → 0x1C2.
  - Each change appears on out_port exactly 1 edge after its write.
- Blink:
  - DATA=0x3FF, BLINK_EN=0x00F, write PERIOD=3 at edge N.
  - phase falls at N+12 and rises at N+24.
  - out_port=0x3F0 from N+13 to N+24, and 0x3FF again from N+25.
- Off bit never lit:
  - DATA=0x000, BLINK_EN=0x3FF → out_port stays 0 for 100 cycles.
- PERIOD=0 and PERIOD restart:
  - Write PERIOD=0 → STATUS=1 and blinking bits steady on for 100 cycles.
  - Write PERIOD=2 in the same cycle as an internal toggle point → phase=1, and the counters restart from 0.
- Mid-operation reset:
  - Assert reset during a DATA write while phase=0.
  - DATA=0x005, phase=1, BLINK_EN=0; the write is discarded.
